// File: rtl/output_delta_unit_if.sv
// Beat-level handshake bundle for the output-layer error stage: activation/sp
// beats in, delta beats plus end-of-sample prediction out.
interface output_delta_unit_if #(
    parameter int pkg_width   = 32,
    parameter int label_width = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [pkg_width-1:0]   a_package;
    logic [pkg_width-1:0]   sp_package;
    logic [label_width-1:0] y_label;
    logic                   out_valid;
    logic                   out_ready;
    logic [pkg_width-1:0]   delta_package;
    logic                   out_last;
    logic [label_width-1:0] predicted;
    logic                   correct;

    modport master (
        output in_valid, a_package, sp_package, y_label, out_ready,
        input  in_ready, out_valid, delta_package, out_last, predicted, correct
    );

    modport slave (
        input  in_valid, a_package, sp_package, y_label, out_ready,
        output in_ready, out_valid, delta_package, out_last, predicted, correct
    );
endinterface

// File: rtl/output_delta_unit.sv
// Output-layer error stage: delta = (a - onehot(label)) * sp per neuron through a
// 2-stage stallable pipeline, with running argmax giving predicted/correct per sample.
module output_delta_unit #(
    parameter int n         = 8,
    parameter int z         = 8,
    parameter int fi        = 4,
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10
) (
    input logic clk,
    input logic reset,
    output_delta_unit_if.slave bus
);
    localparam int unsigned lanes   = z / fi;
    localparam int unsigned beats   = n * fi / z;
    localparam int          beat_w  = (beats > 1) ? $clog2(beats) : 1;
    localparam int          label_w = (n > 1) ? $clog2(n) : 1;

    if ((n * fi) % z != 0 || frac_bits >= width || int_bits >= width) begin : g_bad_cfg
        $error("output_delta_unit: inconsistent parameters");
    end

    logic                      advance, accept, first_beat, last_beat;
    logic [beat_w-1:0]         beat;
    logic [label_w-1:0]        label_q, cur_label;
    logic [width-1:0]          run_max, beat_max;
    logic [label_w-1:0]        run_idx, beat_idx;
    logic signed [width-1:0]   diff   [lanes];
    logic signed [width-1:0]   s1_diff[lanes];
    logic signed [width-1:0]   s1_sp  [lanes];
    logic                      s1_valid, s1_last;
    logic [label_w-1:0]        s1_idx, s1_label;
    logic                      s2_valid, last_q, correct_q;
    logic [lanes*width-1:0]    delta_next, delta_q;
    logic [label_w-1:0]        predicted_q;

    assign advance          = !s2_valid || bus.out_ready;
    assign accept           = bus.in_valid && advance;
    assign first_beat       = (beat == '0);
    assign last_beat        = (beat == beat_w'(beats - 1));
    assign bus.in_ready     = advance;
    assign bus.out_valid    = s2_valid;
    assign bus.delta_package = delta_q;
    assign bus.out_last     = last_q;
    assign bus.predicted    = predicted_q;
    assign bus.correct      = correct_q;

    // Ideal-output subtraction and argmax on the incoming beat; a is non-negative, so
    // starting beat 0 from max=0/idx=0 with strict '>' equals seeding from neuron 0.
    always_comb begin
        logic [width-1:0] a_k;
        int unsigned      gidx;
        cur_label = first_beat ? bus.y_label : label_q;
        beat_max  = first_beat ? '0 : run_max;
        beat_idx  = first_beat ? '0 : run_idx;
        for (int unsigned k = 0; k < lanes; k++) begin
            a_k  = bus.a_package[width*k +: width];
            gidx = 32'(beat) * lanes + k;
            diff[k] = $signed(a_k - ((gidx == 32'(cur_label)) ? (width'(1) << frac_bits) : '0));
            if (a_k > beat_max) begin
                beat_max = a_k;
                beat_idx = label_w'(gidx);
            end
        end
    end

    always_comb begin
        logic signed [2*width-1:0] prod;
        logic [width-frac_bits:0]  upper;
        delta_next = '0;
        for (int unsigned k = 0; k < lanes; k++) begin
            prod  = (2*width)'(s1_diff[k]) * (2*width)'(s1_sp[k]);
            upper = prod[2*width-1 : frac_bits+width-1];
            if (upper == '0 || upper == '1)
                delta_next[width*k +: width] = prod[frac_bits+width-1 : frac_bits];
            else if (prod[2*width-1])
                delta_next[width*k +: width] = {1'b1, {(width-1){1'b0}}};
            else
                delta_next[width*k +: width] = {1'b0, {(width-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat        <= '0;
            label_q     <= '0;
            run_max     <= '0;
            run_idx     <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_idx      <= '0;
            s1_label    <= '0;
            s1_diff     <= '{default: '0};
            s1_sp       <= '{default: '0};
            s2_valid    <= 1'b0;
            last_q      <= 1'b0;
            delta_q     <= '0;
            predicted_q <= '0;
            correct_q   <= 1'b0;
        end else begin
            if (accept) begin
                beat    <= last_beat ? '0 : beat + 1'b1;
                run_max <= beat_max;
                run_idx <= beat_idx;
                if (first_beat) label_q <= bus.y_label;
            end
            if (advance) begin
                s1_valid <= bus.in_valid;
                s1_last  <= last_beat;
                s1_idx   <= beat_idx;
                s1_label <= cur_label;
                s1_diff  <= diff;
                for (int unsigned k = 0; k < lanes; k++)
                    s1_sp[k] <= $signed(bus.sp_package[width*k +: width]);
                s2_valid <= s1_valid;
                last_q   <= s1_valid && s1_last;
                if (s1_valid) begin
                    delta_q <= delta_next;
                    if (s1_last) begin
                        predicted_q <= s1_idx;
                        correct_q   <= (s1_idx == s1_label);
                    end
                end
            end
        end
    end
endmodule
